// File: rtl/mine_placer.sv
// mine_placer: clears the board then places NUM_MINES distinct mines via BlockRAM's write port; MINE_PLACER_SAFE_RING_EN also keeps the 8 neighbours of safeID clear
module mine_placer #(
  parameter int ROWS = 5,
  parameter int COLS = 5,
  parameter int NUM_MINES = 5,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [15:0]       seed,
  input  logic [31:0]       safeID,
  output logic              busy,
  output logic              done,
  output logic              wEn,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] dataIn
);
  localparam int CELLS = ROWS * COLS;
  localparam logic [7:0] LAST_CELL = 8'(CELLS - 1);
  localparam logic [7:0] LAST_MINE = 8'(NUM_MINES - 1);
  if (CELLS > 256) begin : g_cells_err
    $error("mine_placer: ROWS*COLS exceeds 256");
  end
`ifdef MINE_PLACER_SAFE_RING_EN
  if (NUM_MINES > CELLS - 9) begin : g_mines_err
    $error("mine_placer: NUM_MINES too large for safe ring");
  end
`else
  if (NUM_MINES > CELLS - 1) begin : g_mines_err
    $error("mine_placer: NUM_MINES too large");
  end
`endif
  typedef enum logic [1:0] {IDLE, CLEAR, PLACE, DONE} state_t;
  state_t state, state_n;
  logic [15:0] lfsr;
  logic [7:0] ptr, count, cand, wr_addr;
  logic [255:0] bitmap;
  logic [31:0] safe_id;
  logic in_board, safe_valid, excl, accept, wr, wr_data, cap;
  assign cand = lfsr[7:0];
  assign in_board = {1'b0, cand} < 9'(CELLS);
  assign safe_valid = safe_id < 32'(CELLS);
`ifdef MINE_PLACER_SAFE_RING_EN
  logic [8:0] cr, cc, sr, sc;
  assign cr = 9'(32'(cand) / COLS);
  assign cc = 9'(32'(cand) % COLS);
  assign sr = 9'(safe_id / COLS);
  assign sc = 9'(safe_id % COLS);
  // row/col distance compare clips at board edges without wrapping
  assign excl = safe_valid && (cr + 9'd1 >= sr) && (cr <= sr + 9'd1) && (cc + 9'd1 >= sc) && (cc <= sc + 9'd1);
`else
  assign excl = safe_valid && (32'(cand) == safe_id);
`endif
  assign busy = (state == CLEAR) || (state == PLACE);
  assign done = state == DONE;
  always_comb begin
    state_n = state;
    accept = 1'b0;
    wr = 1'b0;
    wr_addr = ptr;
    wr_data = 1'b0;
    cap = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        cap = start;
        state_n = start ? CLEAR : state;
      end
      CLEAR: begin
        wr = 1'b1;
        state_n = (ptr == LAST_CELL) ? PLACE : CLEAR;
      end
      PLACE: begin
        accept = in_board && !bitmap[cand] && !excl;
        wr = accept;
        wr_addr = cand;
        wr_data = 1'b1;
        state_n = (accept && count == LAST_MINE) ? DONE : PLACE;
      end
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      wEn <= 1'b0;
      addr <= '0;
      dataIn <= '0;
      bitmap <= '0;
      count <= '0;
      ptr <= '0;
      lfsr <= LFSR_SEED;
      safe_id <= '0;
    end else begin
      state <= state_n;
      wEn <= wr;
      addr <= ADDR_W'(wr_addr);
      dataIn <= DATA_W'(wr_data);
      if (cap) begin
        ptr <= '0;
        bitmap <= '0;
        count <= '0;
        safe_id <= safeID;
        lfsr <= (seed == 16'd0) ? LFSR_SEED : seed;
      end
      if (state == CLEAR) ptr <= ptr + 8'd1;
      if (state == PLACE) begin
        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        if (accept) begin
          bitmap[cand] <= 1'b1;
          count <= count + 8'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_mine_placer.sv
// tb_mine_placer: scoreboard bench; a spec-level placement model predicts every BlockRAM write
module tb_mine_placer;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic [15:0] seed = '0;
  logic [31:0] safeID = '0;
  logic busy, done, wEn;
  logic [11:0] addr;
  logic [31:0] dataIn;
  typedef struct packed {logic [7:0] a; logic d; logic last;} wr_t;
  wr_t sb[$];
  int tests = 0, fails = 0, wr_cnt = 0, done_rises = 0;
  logic prev_done = 1'b0;
  logic mem [0:24];
  mine_placer dut (
    .clk(clk), .reset_n(reset_n), .start(start), .seed(seed), .safeID(safeID),
    .busy(busy), .done(done), .wEn(wEn), .addr(addr), .dataIn(dataIn)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [15:0] step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction
  function automatic bit near_safe(input int c, input int s);
    int dr, dc;
    if (s >= 25) return 1'b0;
`ifdef MINE_PLACER_SAFE_RING_EN
    dr = c / 5 - s / 5;
    dc = c % 5 - s % 5;
    return dr >= -1 && dr <= 1 && dc >= -1 && dc <= 1;
`else
    dr = 0;
    dc = 0;
    return c == s + dr + dc;
`endif
  endfunction
  task automatic push_model(input logic [15:0] sd, input logic [31:0] sf);
    logic [15:0] l;
    bit bm [0:24];
    int n;
    wr_t e;
    l = (sd == 16'd0) ? 16'hACE1 : sd;
    for (int i = 0; i < 25; i++) begin
      bm[i] = 1'b0;
      e.a = 8'(i);
      e.d = 1'b0;
      e.last = 1'b0;
      sb.push_back(e);
    end
    n = 0;
    for (int k = 0; k < 65536 && n < 5; k++) begin
      if (l[7:0] < 8'd25 && !bm[l[7:0]] && !near_safe(int'(l[7:0]), (sf >= 32'd25) ? 25 : int'(sf))) begin
        bm[l[7:0]] = 1'b1;
        n++;
        e.a = l[7:0];
        e.d = 1'b1;
        e.last = (n == 5);
        sb.push_back(e);
      end
      l = step(l);
    end
  endtask
  always @(negedge clk) begin
    wr_t e;
    if (reset_n && done && !prev_done) done_rises++;
    prev_done = done;
    if (reset_n && wEn) begin
      wr_cnt++;
      if (addr < 12'd25) mem[addr] = dataIn[0];
      if (sb.size() == 0) check("unexpected_write", 64'(addr), 64'hFFFF);
      else begin
        e = sb.pop_front();
        check("wr_addr", 64'(addr), 64'(e.a));
        check("wr_data", 64'(dataIn), 64'(e.d));
        check("wr_done", 64'(done), 64'(e.last));
      end
    end
  end
  task automatic run_start(input logic [15:0] sd, input logic [31:0] sf);
    @(posedge clk);
    #1;
    wr_cnt = 0;
    done_rises = 0;
    seed = sd;
    safeID = sf;
    push_model(sd, sf);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    seed = 16'hFFFF;
    safeID = 32'd3;
  endtask
  task automatic wait_done(input logic [31:0] sf);
    int ones, nb;
    for (int i = 0; i < 4000 && !done; i++) @(negedge clk);
    check("done_timeout", 64'(done), 64'd1);
    repeat (2) @(negedge clk);
    check("wr_count", 64'(wr_cnt), 64'd30);
    check("sb_empty", 64'(sb.size()), 64'd0);
    check("done_once", 64'(done_rises), 64'd1);
    check("busy_after", 64'(busy), 64'd0);
    ones = 0;
    for (int i = 0; i < 25; i++) ones += int'(mem[i]);
    check("mine_total", 64'(ones), 64'd5);
    if (sf < 32'd25) begin
      check("safe_clear", 64'(mem[sf]), 64'd0);
      nb = 0;
      for (int i = 0; i < 25; i++)
        if (i != int'(sf) && (i / 5 - int'(sf) / 5) inside {[-1:1]} && (i % 5 - int'(sf) % 5) inside {[-1:1]})
          nb += int'(mem[i]);
`ifdef MINE_PLACER_SAFE_RING_EN
      check("ring_numarray", 64'(nb), 64'd0);
`endif
    end
    sb.delete();
  endtask
  initial begin
    for (int i = 0; i < 25; i++) mem[i] = 1'b1;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_wen", 64'(wEn), 64'd0);
    check("rst_addr", 64'(addr), 64'd0);
    #20 reset_n = 1'b1;
    run_start(16'h1234, 32'd12);
    wait_done(32'd12);
    run_start(16'h0, 32'd7);
    wait_done(32'd7);
    run_start(16'hACE1, 32'd7);
    wait_done(32'd7);
    run_start(16'h1234, 32'd12);
    wait_done(32'd12);
    run_start(16'h5A5A, 32'd3);
    repeat (5) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (24) @(posedge clk);
    #1 start = busy;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(32'd3);
    run_start(16'h1234, 32'd100);
    wait_done(32'd100);
    run_start(16'hBEEF, 32'd12);
    repeat (10) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("mid_busy", 64'(busy), 64'd0);
    check("mid_done", 64'(done), 64'd0);
    check("mid_wen", 64'(wEn), 64'd0);
    check("mid_addr", 64'(addr), 64'd0);
    sb.delete();
    @(posedge clk);
    #1 reset_n = 1'b1;
    run_start(16'hBEEF, 32'd12);
    wait_done(32'd12);
    run_start(16'h9876, 32'd0);
    wait_done(32'd0);
    run_start(16'h0F0F, 32'd24);
    wait_done(32'd24);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
